sha256_pad: RTL and testbench

//  Message padder and framer that feeds the sha256 core input interface.
//  - Accepts a raw message as 32-bit beats; the final beat may be partial.
//  - Appends the 0x80 marker, zero fill and the 64-bit big-endian bit length.
//  - Emits complete 16-word blocks on a valid/ready stream.
//  - Flags the final word of the final block with out_last_o, so the core sees pre-padded blocks only.

---
 rtl/sha256_pkg.sv | 42 ++++
 rtl/sha256_pad.sv | 130 +++++++++++++
 tb/tb_sha256_pad.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and the word-builder helper for the SHA-256 front end.
// A 32-bit word carries the first message byte in bits [31:24].
package sha256_pkg;

  localparam int D_WIDTH   = 32;
  localparam int BLK_WORDS = 16;
  localparam int LEN_WIDTH = 64;
  localparam int WCNT_W    = $clog2(BLK_WORDS);

  localparam logic [D_WIDTH-1:0] PAD_WORD = 32'h8000_0000;

  // Index of the last fill word; the two length words occupy the slots after it.
  localparam logic [WCNT_W-1:0] LAST_FILL_IDX = WCNT_W'(BLK_WORDS - 3);

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PAD,
    LEN_HI,
    LEN_LO
  } pad_state_t;

  // Keeps the valid leading bytes of a final partial beat, drops the 0x80 marker
  // right after them and zero-fills the rest. Full or non-final beats pass through.
  function automatic logic [D_WIDTH-1:0] build_word(input logic [D_WIDTH-1:0] data,
                                                    input logic [2:0]         nbytes,
                                                    input logic               last);
    logic [D_WIDTH-1:0] w;
    w = data;
    if (last) begin
      case (nbytes)
        3'd0:    w = PAD_WORD;
        3'd1:    w = {data[31:24], 24'h80_0000};
        3'd2:    w = {data[31:16], 16'h8000};
        3'd3:    w = {data[31:8], 8'h80};
        default: w = data;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/sha256_pad.sv
// SHA-256 message padder: turns a byte-counted beat stream into complete 16-word blocks
// carrying the 0x80 marker, zero fill and the 64-bit big-endian bit length.
module sha256_pad
  import sha256_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [D_WIDTH-1:0] in_data_i,
  input  logic [2:0]         in_bytes_i,
  input  logic               in_last_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  output logic [D_WIDTH-1:0] out_data_o,
  output logic               out_last_o,
  output logic               out_valid_o,
  input  logic               out_ready_i
);

  pad_state_t            state_q, state_d;
  logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  need80_q, need80_d;
  logic [D_WIDTH-1:0]    out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;
  logic                  adv;
  logic                  in_ready;

  assign adv = ~out_valid_q | out_ready_i;

  // in_ready is forced low while reset is held so nothing is taken during reset.
  assign in_ready_o  = in_ready & ~rst_i;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign out_valid_o = out_valid_q;

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    len_d       = len_q;
    need80_d    = need80_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    in_ready    = 1'b0;

    if (adv) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      IDLE, DATA: begin
        in_ready = adv;
        if (in_valid_i && adv) begin
          out_valid_d = 1'b1;
          out_data_d  = build_word(in_data_i, in_bytes_i, in_last_i);
          wcnt_d      = wcnt_q + 1'b1;
          len_d       = len_q + LEN_WIDTH'({in_bytes_i, 3'b000});
          if (!in_last_i) begin
            state_d = DATA;
          end else if (in_bytes_i == 3'd4) begin
            // A full final beat leaves no room for the marker; it goes out as its own word.
            state_d  = PAD;
            need80_d = 1'b1;
          end else begin
            state_d = (wcnt_q == LAST_FILL_IDX) ? LEN_HI : PAD;
          end
        end
      end

      PAD: begin
        if (adv) begin
          out_valid_d = 1'b1;
          out_data_d  = need80_q ? PAD_WORD : '0;
          need80_d    = 1'b0;
          wcnt_d      = wcnt_q + 1'b1;
          state_d     = (wcnt_q == LAST_FILL_IDX) ? LEN_HI : PAD;
        end
      end

      LEN_HI: begin
        if (adv) begin
          out_valid_d = 1'b1;
          out_data_d  = len_q[LEN_WIDTH-1:D_WIDTH];
          wcnt_d      = wcnt_q + 1'b1;
          state_d     = LEN_LO;
        end
      end

      LEN_LO: begin
        if (adv) begin
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          out_data_d  = len_q[D_WIDTH-1:0];
          wcnt_d      = wcnt_q + 1'b1;
          len_d       = '0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      len_q       <= '0;
      need80_q    <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      len_q       <= len_d;
      need80_q    <= need80_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Only the final beat may be partial, and never more than four bytes.
  a_legal_beat : assert property (@(posedge clk_i) disable iff (rst_i)
    (in_valid_i && in_ready_o) |-> ((in_bytes_i <= 3'd4) && (in_last_i || in_bytes_i == 3'd4)));

endmodule

// File: tb/tb_sha256_pad.sv
// Directed bench for sha256_pad: table-driven spot checks over several message lengths,
// plus hand-written backpressure and reset-mid-message sequences.
module tb_sha256_pad;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] in_data_i = '0;
  logic [2:0]  in_bytes_i = '0;
  logic        in_last_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] out_data_o;
  logic        out_last_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;

  sha256_pad dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_data_i   (in_data_i),
    .in_bytes_i  (in_bytes_i),
    .in_last_i   (in_last_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          nbytes;
    int          idx;
    logic [31:0] data;
    logic        last;
    int          total;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] got_data[$];
  bit          got_last[$];
  int          n_last = 0;
  int          n_stall = 0;
  int          n_unstable = 0;
  bit          stall_mode = 1'b0;
  bit          hold_mode = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Downstream model: always ready, random 50%, and optionally a 5-cycle hold on the length LSW.
  initial begin
    int hold_cnt;
    hold_cnt = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (!(out_valid_o && out_last_o)) hold_cnt = 0;
      if (hold_mode && out_valid_o && out_last_o && hold_cnt < 5) begin
        out_ready_i = 1'b0;
        hold_cnt++;
      end else if (stall_mode) begin
        out_ready_i = 1'($urandom_range(0, 1));
      end else begin
        out_ready_i = 1'b1;
      end
    end
  end

  // Captures accepted words and watches for output changes while stalled.
  initial begin
    bit          stalled;
    logic [31:0] held_data;
    logic        held_last;
    stalled = 1'b0;
    held_data = '0;
    held_last = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          n_stall++;
          if (!out_valid_o || out_data_o !== held_data || out_last_o !== held_last) n_unstable++;
        end
        if (out_valid_o && out_ready_i) begin
          got_data.push_back(out_data_o);
          got_last.push_back(out_last_o);
          if (out_last_o) n_last++;
        end
        stalled   = out_valid_o && !out_ready_i;
        held_data = out_data_o;
        held_last = out_last_o;
      end
    end
  end

  // Message byte k is 0x61+k ("abc..."); bytes past the message end are junk the DUT must drop.
  task automatic applyStimulus(input int nbytes, input int max_beats, input bit gaps);
    int beats;
    int b;
    int tries;
    bit accepted;
    logic [31:0] w;
    beats = (nbytes == 0) ? 1 : (nbytes + 3) / 4;
    b = 0;
    tries = 0;
    while (b < beats && b < max_beats) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid_i = 1'b0;
      end else begin
        for (int k = 0; k < 4; k++)
          w[31-8*k -: 8] = (4*b + k < nbytes) ? 8'(8'h61 + 4*b + k) : 8'hEE;
        in_data_i  = w;
        in_bytes_i = 3'((nbytes - 4*b > 4) ? 4 : nbytes - 4*b);
        in_last_i  = (b == beats - 1);
        in_valid_i = 1'b1;
      end
      @(negedge clk_i);
      accepted = in_valid_i && in_ready_o;
      @(posedge clk_i);
      #1;
      if (accepted) b++;
      tries++;
      if (tries >= 2000) begin
        checkOutput("in_ready_timeout", 32'(b), 32'(beats));
        break;
      end
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic runMessage(input int nbytes, input bit stall, output int base, output int cnt);
    int start_last;
    base = got_data.size();
    start_last = n_last;
    stall_mode = stall;
    hold_mode  = stall;
    applyStimulus(nbytes, 1000, stall);
    for (int c = 0; c < 3000 && n_last == start_last; c++) @(posedge clk_i);
    @(posedge clk_i);
    #1;
    stall_mode = 1'b0;
    hold_mode  = 1'b0;
    checkOutput($sformatf("done_len%0d", nbytes), 32'(n_last - start_last), 32'd1);
    cnt = got_data.size() - base;
  endtask

  function automatic logic [31:0] wordAt(input int base, input int cnt, input int idx);
    return (idx < cnt) ? got_data[base + idx] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic lastAt(input int base, input int cnt, input int idx);
    return (idx < cnt) ? got_last[base + idx] : 1'b0;
  endfunction

  // Checks a whole 16-word single-block capture: marker word, zeros, then length words.
  task automatic checkSingleBlock(input string name, input int base, input int cnt,
                                  input logic [31:0] w0, input logic [31:0] len_lo);
    logic [31:0] exp;
    checkOutput({name, "_total"}, 32'(cnt), 32'd16);
    for (int i = 0; i < 16; i++) begin
      exp = (i == 0) ? w0 : (i == 15) ? len_lo : 32'h0;
      checkOutput($sformatf("%s_w%0d", name, i), wordAt(base, cnt, i), exp);
      checkOutput($sformatf("%s_l%0d", name, i), 32'(lastAt(base, cnt, i)), 32'(i == 15));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[27];
    int   cur;
    int   base;
    int   cnt;
    int   nl;
    int   ref_base;
    int   ref_cnt;

    vecs[0]  = '{3,  0,  32'h6162_6380, 1'b0, 16};
    vecs[1]  = '{3,  13, 32'h0000_0000, 1'b0, 16};
    vecs[2]  = '{3,  14, 32'h0000_0000, 1'b0, 16};
    vecs[3]  = '{3,  15, 32'h0000_0018, 1'b1, 16};
    vecs[4]  = '{0,  0,  32'h8000_0000, 1'b0, 16};
    vecs[5]  = '{0,  15, 32'h0000_0000, 1'b1, 16};
    vecs[6]  = '{9,  2,  32'h6980_0000, 1'b0, 16};
    vecs[7]  = '{9,  15, 32'h0000_0048, 1'b1, 16};
    vecs[8]  = '{55, 12, 32'h9192_9394, 1'b0, 16};
    vecs[9]  = '{55, 13, 32'h9596_9780, 1'b0, 16};
    vecs[10] = '{55, 14, 32'h0000_0000, 1'b0, 16};
    vecs[11] = '{55, 15, 32'h0000_01B8, 1'b1, 16};
    vecs[12] = '{56, 0,  32'h6162_6364, 1'b0, 32};
    vecs[13] = '{56, 13, 32'h9596_9798, 1'b0, 32};
    vecs[14] = '{56, 14, 32'h8000_0000, 1'b0, 32};
    vecs[15] = '{56, 15, 32'h0000_0000, 1'b0, 32};
    vecs[16] = '{56, 30, 32'h0000_0000, 1'b0, 32};
    vecs[17] = '{56, 31, 32'h0000_01C0, 1'b1, 32};
    vecs[18] = '{60, 14, 32'h999A_9B9C, 1'b0, 32};
    vecs[19] = '{60, 15, 32'h8000_0000, 1'b0, 32};
    vecs[20] = '{60, 31, 32'h0000_01E0, 1'b1, 32};
    vecs[21] = '{62, 15, 32'h9D9E_8000, 1'b0, 32};
    vecs[22] = '{62, 16, 32'h0000_0000, 1'b0, 32};
    vecs[23] = '{62, 31, 32'h0000_01F0, 1'b1, 32};
    vecs[24] = '{64, 15, 32'h9D9E_9FA0, 1'b0, 32};
    vecs[25] = '{64, 16, 32'h8000_0000, 1'b0, 32};
    vecs[26] = '{64, 31, 32'h0000_0200, 1'b1, 32};

    // Reset values.
    @(negedge clk_i);
    checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("rst_out_last",  32'(out_last_o),  32'd0);
    checkOutput("rst_out_data",  out_data_o,       32'd0);
    checkOutput("rst_in_ready",  32'(in_ready_o),  32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    cur = -1;
    base = 0;
    cnt = 0;
    for (int i = 0; i < 27; i++) begin
      if (vecs[i].nbytes != cur) begin
        cur = vecs[i].nbytes;
        runMessage(cur, 1'b0, base, cnt);
        checkOutput($sformatf("len%0d_total", cur), 32'(cnt), 32'(vecs[i].total));
        nl = 0;
        for (int j = 0; j < cnt; j++) if (got_last[base + j]) nl++;
        checkOutput($sformatf("len%0d_last_count", cur), 32'(nl), 32'd1);
      end
      checkOutput($sformatf("len%0d_w%0d", cur, vecs[i].idx),
                  wordAt(base, cnt, vecs[i].idx), vecs[i].data);
      checkOutput($sformatf("len%0d_l%0d", cur, vecs[i].idx),
                  32'(lastAt(base, cnt, vecs[i].idx)), 32'(vecs[i].last));
    end

    // Empty message, every word.
    runMessage(0, 1'b0, base, cnt);
    checkSingleBlock("empty", base, cnt, 32'h8000_0000, 32'h0000_0000);

    // Backpressure: stalled run must match the unstalled 56-byte run word for word.
    runMessage(56, 1'b0, ref_base, ref_cnt);
    n_stall = 0;
    n_unstable = 0;
    runMessage(56, 1'b1, base, cnt);
    checkOutput("bp_total", 32'(cnt), 32'(ref_cnt));
    for (int i = 0; i < 32; i++) begin
      checkOutput($sformatf("bp_w%0d", i), wordAt(base, cnt, i), wordAt(ref_base, ref_cnt, i));
      checkOutput($sformatf("bp_l%0d", i), 32'(lastAt(base, cnt, i)), 32'(i == 31));
    end
    checkOutput("bp_unstable_cycles", 32'(n_unstable), 32'd0);
    checkOutput("bp_hold_seen", 32'(n_stall >= 5), 32'd1);

    // Reset after 5 beats of a 64-byte message, then "abc".
    applyStimulus(64, 5, 1'b0);
    rst_i = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checkOutput($sformatf("midrst_valid_c%0d", c), 32'(out_valid_o), 32'd0);
      checkOutput($sformatf("midrst_ready_c%0d", c), 32'(in_ready_o), 32'd0);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checkOutput($sformatf("postrst_idle_c%0d", c), 32'(out_valid_o), 32'd0);
    end
    @(posedge clk_i);
    #1;
    runMessage(3, 1'b0, base, cnt);
    checkSingleBlock("abc_after_rst", base, cnt, 32'h6162_6380, 32'h0000_0018);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
